single_port_ram_responder: RTL and testbench

- Behavioural responder for the single-port RAM access interface: ram_en, ram_we, addr, din and dout.
- Replaces the vendor RAM IP in simulation and portable builds, and sits directly under an access driver such as the RAM read/write sequencer.
- Adds a power-up clear sweep, selectable write-collision read mode, per-access status and access counters.

---
 rtl/single_port_ram_responder.sv | 166 ++++++++++++++++
 tb/tb_single_port_ram_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_port_ram_responder.sv
// Behavioural single-port RAM responder: clear sweep after reset,
// selectable write-collision read mode, access status and counters.
//
// Ports:
//   sys_clk    rising-edge clock
//   sys_rst    asynchronous active-low reset
//   ram_en     access enable
//   ram_we     1 = write, 0 = read (qualified by ram_en)
//   addr       word address
//   din        write data
//   dout       registered read data (1-cycle latency)
//   rd_valid   pulse: dout holds the result of a read
//   init_done  high once the clear sweep has finished
//   access_err pulse: access rejected (during sweep or out of range)
//   wr_cnt     accepted writes, saturating
//   rd_cnt     accepted reads, saturating
module single_port_ram_responder #(
    parameter int              ADDR_W   = 5,
    parameter int              DATA_W   = 8,
    parameter int              DEPTH    = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter int              WR_MODE  = 0,
    parameter int              CNT_W    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              ram_en,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              init_done,
    output logic              access_err,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic MODE_RF = (WR_MODE == 1);
    localparam logic MODE_WF = (WR_MODE == 2);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [IDX_W-1:0] clr_ptr;
    logic [IDX_W-1:0] clr_ptr_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              run;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              rd_ok;
    logic              wr_ok;
    logic              rej;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Single-stage release synchroniser: the FSM first acts on the
    // second rising edge after sys_rst goes high.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Access qualification
    always_comb begin
        in_range = ({1'b0, addr} < DEPTH_L);
        idx      = addr[IDX_W-1:0];
        rd_ok    = run && (state == READY) && ram_en
                   && !ram_we && in_range;
        wr_ok    = run && (state == READY) && ram_en
                   && ram_we && in_range;
        rej      = run && ram_en
                   && ((state == INIT) || !in_range);
    end

    // Next state and the single memory write port
    always_comb begin
        state_nxt   = state;
        clr_ptr_nxt = clr_ptr;
        mem_we      = 1'b0;
        mem_waddr   = idx;
        mem_wdata   = din;
        if (run) begin
            unique case (state)
                INIT: begin
                    mem_we      = 1'b1;
                    mem_waddr   = clr_ptr;
                    mem_wdata   = INIT_VAL;
                    clr_ptr_nxt = clr_ptr + 1'b1;
                    if (clr_ptr == LAST) begin
                        state_nxt   = READY;
                        clr_ptr_nxt = '0;
                    end
                end
                READY: begin
                    mem_we = wr_ok;
                end
                default: begin
                    state_nxt = INIT;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep defines its contents.
    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= INIT;
            clr_ptr    <= '0;
            dout       <= '0;
            rd_valid   <= 1'b0;
            init_done  <= 1'b0;
            access_err <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            clr_ptr    <= clr_ptr_nxt;
            rd_valid   <= rd_ok;
            access_err <= rej;
            init_done  <= (state_nxt == READY);

            // mem read here sees the pre-write contents, which is
            // exactly what READ_FIRST wants.
            if (rd_ok) begin
                dout <= mem[idx];
            end else if (wr_ok && MODE_RF) begin
                dout <= mem[idx];
            end else if (wr_ok && MODE_WF) begin
                dout <= din;
            end

            if (rd_ok && (rd_cnt != CNT_MAX)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (wr_ok && (wr_cnt != CNT_MAX)) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_single_port_ram_responder.sv
// Self-checking bench for single_port_ram_responder.
// Four instances share stimulus: default, READ_FIRST, WRITE_FIRST, DEPTH=20/CNT_W=4.
module tb_single_port_ram_responder;

    logic       clk;
    logic       sys_rst;
    logic       ram_en;
    logic       ram_we;
    logic [4:0] addr;
    logic [7:0] din;

    logic [7:0]  d0, d1, d2, d3;
    logic        rv0, rv1, rv2, rv3;
    logic        id0, id1, id2, id3;
    logic        ae0, ae1, ae2, ae3;
    logic [15:0] wc0, rc0, wc1, rc1, wc2, rc2;
    logic [3:0]  wc3, rc3;

    int n_cmp = 0;
    int n_bad = 0;

    single_port_ram_responder u0 (
        .sys_clk(clk), .sys_rst(sys_rst), .ram_en(ram_en),
        .ram_we(ram_we), .addr(addr), .din(din), .dout(d0),
        .rd_valid(rv0), .init_done(id0), .access_err(ae0),
        .wr_cnt(wc0), .rd_cnt(rc0)
    );

    single_port_ram_responder #(.WR_MODE(1)) u1 (
        .sys_clk(clk), .sys_rst(sys_rst), .ram_en(ram_en),
        .ram_we(ram_we), .addr(addr), .din(din), .dout(d1),
        .rd_valid(rv1), .init_done(id1), .access_err(ae1),
        .wr_cnt(wc1), .rd_cnt(rc1)
    );

    single_port_ram_responder #(.WR_MODE(2)) u2 (
        .sys_clk(clk), .sys_rst(sys_rst), .ram_en(ram_en),
        .ram_we(ram_we), .addr(addr), .din(din), .dout(d2),
        .rd_valid(rv2), .init_done(id2), .access_err(ae2),
        .wr_cnt(wc2), .rd_cnt(rc2)
    );

    single_port_ram_responder #(.DEPTH(20), .CNT_W(4)) u3 (
        .sys_clk(clk), .sys_rst(sys_rst), .ram_en(ram_en),
        .ram_we(ram_we), .addr(addr), .din(din), .dout(d3),
        .rd_valid(rv3), .init_done(id3), .access_err(ae3),
        .wr_cnt(wc3), .rd_cnt(rc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of u0 (DEPTH 32, NO_CHANGE, 16-bit counters)
    logic [7:0]  m_mem [32];
    logic [7:0]  m_dout;
    logic [15:0] m_wc, m_rc;
    bit          m_run, m_ready;
    int          m_ptr;

    typedef struct {
        logic [7:0]  dout;
        logic        rv;
        logic        id;
        logic        ae;
        logic [15:0] wc;
        logic [15:0] rc;
    } exp_t;

    exp_t sbq [$];

    typedef struct {
        logic       en;
        logic       we;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] x0;
        logic [7:0] x1;
        logic [7:0] x2;
        logic       rv;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_dout  = 8'h00;
        m_wc    = 16'h0;
        m_rc    = 16'h0;
        m_run   = 1'b0;
        m_ready = 1'b0;
        m_ptr   = 0;
        sbq.delete();
    endtask

    // Drive one cycle of stimulus, predict u0, check after the edge
    task automatic step(input logic en, input logic we,
                        input logic [4:0] a, input logic [7:0] d);
        exp_t e;
        exp_t g;
        ram_en = en;
        ram_we = we;
        addr   = a;
        din    = d;
        e.rv = 1'b0;
        e.ae = 1'b0;
        if (!m_run) begin
            m_run = 1'b1;
        end else if (!m_ready) begin
            e.ae = en;
            m_mem[m_ptr] = 8'h00;
            m_ptr++;
            if (m_ptr == 32) m_ready = 1'b1;
        end else if (en) begin
            if (we) begin
                m_mem[a] = d;
                if (m_wc != 16'hFFFF) m_wc++;
            end else begin
                m_dout = m_mem[a];
                e.rv = 1'b1;
                if (m_rc != 16'hFFFF) m_rc++;
            end
        end
        e.dout = m_dout;
        e.id   = m_ready;
        e.wc   = m_wc;
        e.rc   = m_rc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        g = sbq.pop_front();
        chk("u0.dout", d0, g.dout);
        chk("u0.rd_valid", rv0, g.rv);
        chk("u0.init_done", id0, g.id);
        chk("u0.access_err", ae0, g.ae);
        chk("u0.cnts", {wc0, rc0}, {g.wc, g.rc});
    endtask

    // Assert reset between edges, check async clear, release after an edge
    task automatic apply_reset();
        #3;
        sys_rst = 1'b0;
        #1;
        chk("u0.rst_outs", {d0, rv0, id0, ae0, wc0, rc0}, 64'h0);
        chk("u1.rst_outs", {d1, rv1, id1, ae1, wc1, rc1}, 64'h0);
        chk("u2.rst_outs", {d2, rv2, id2, ae2, wc2, rc2}, 64'h0);
        chk("u3.rst_outs", {d3, rv3, id3, ae3, wc3, rc3}, 64'h0);
        model_reset();
        @(posedge clk);
        #1;
        ram_en  = 1'b0;
        sys_rst = 1'b1;
    endtask

    initial begin
        sys_rst = 1'b1;
        ram_en  = 1'b0;
        ram_we  = 1'b0;
        addr    = '0;
        din     = '0;

        tbl[0] = '{1'b1, 1'b0, 5'd3 + 5'd2, 8'h00, 8'h15, 8'h15, 8'h15, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 5'd3, 8'hAA, 8'h15, 8'h13, 8'hAA, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 5'd3, 8'h55, 8'h15, 8'hAA, 8'h55, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 5'd3, 8'h00, 8'h55, 8'h55, 8'h55, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 5'd3, 8'hFF, 8'h55, 8'h55, 8'h55, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 5'd9, 8'h99, 8'h55, 8'h19, 8'h99, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 5'd9, 8'h00, 8'h99, 8'h99, 8'h99, 1'b1};

        @(posedge clk);
        #1;
        apply_reset();

        // Sweep, with an access attempted in sweep cycle 5
        for (int e = 1; e <= 34; e++) begin
            if (e == 6) step(1'b1, 1'b1, 5'd1, 8'hEE);
            else        step(1'b0, 1'b0, 5'd0, 8'h00);
            chk("u3.init_done", id3, (e >= 21));
            if (e == 6) begin
                chk("u1.init_err", ae1, 1'b1);
                chk("u3.init_err_wc", {ae3, wc3}, {1'b1, 4'd0});
            end
        end

        // Read the cleared array
        for (int a = 0; a < 32; a++) begin
            step(1'b1, 1'b0, 5'(a), 8'h00);
            chk("u3.rd_err", {ae3, rv3}, {(a >= 20), (a < 20)});
        end
        chk("u0.rd_cnt32", rc0, 16'd32);

        // Fill with addr + 0x10 and read back back-to-back
        for (int a = 0; a < 32; a++) begin
            step(1'b1, 1'b1, 5'(a), 8'(a + 16));
            chk("u3.wr_err", ae3, (a >= 20));
            chk("u3.wr_cnt", wc3, (a < 20) ? ((a < 15) ? a + 1 : 15) : 15);
        end
        for (int a = 0; a < 32; a++) begin
            step(1'b1, 1'b0, 5'(a), 8'h00);
            chk("u0.readback", d0, 8'(a + 16));
        end
        chk("u0.cnts_fill", {wc0, rc0}, {16'd32, 16'd64});

        // Write-collision modes
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].en, tbl[i].we, tbl[i].a, tbl[i].d);
            chk("u0.mode_dout", d0, tbl[i].x0);
            chk("u1.mode_dout", d1, tbl[i].x1);
            chk("u2.mode_dout", d2, tbl[i].x2);
            chk("u3.mode_dout", d3, tbl[i].x0);
            chk("u1.mode_rv", rv1, tbl[i].rv);
            chk("u2.mode_rv", rv2, tbl[i].rv);
        end

        // Out-of-range on the 20-word instance
        step(1'b1, 1'b0, 5'd3, 8'h00);
        step(1'b1, 1'b0, 5'd25, 8'h00);
        chk("u3.oor_rd", {ae3, rv3, d3}, {1'b1, 1'b0, 8'h55});
        step(1'b1, 1'b1, 5'd25, 8'h77);
        chk("u3.oor_wr", {ae3, rv3, d3}, {1'b1, 1'b0, 8'h55});

        // Mid-stream reset
        step(1'b1, 1'b1, 5'd7, 8'hC3);
        step(1'b1, 1'b0, 5'd7, 8'h00);
        apply_reset();
        for (int e = 1; e <= 34; e++) begin
            if (e == 23)      step(1'b1, 1'b1, 5'd25, 8'h77);
            else if (e == 24) step(1'b1, 1'b0, 5'd25, 8'h00);
            else              step(1'b0, 1'b0, 5'd0, 8'h00);
            chk("u3.init_done2", id3, (e >= 21));
            if (e == 23) chk("u3.oor_wc", {ae3, wc3}, {1'b1, 4'd0});
            if (e == 24) begin
                chk("u3.oor_rc", {ae3, rv3, rc3}, {1'b1, 1'b0, 4'd0});
                chk("u3.oor_dout", d3, 8'h00);
            end
        end
        step(1'b1, 1'b0, 5'd7, 8'h00);
        chk("u1.reinit_rd", {rv1, d1}, {1'b1, 8'h00});
        chk("u2.reinit_rd", {rv2, d2}, {1'b1, 8'h00});
        chk("u3.reinit_rd", {rv3, d3}, {1'b1, 8'h00});

        // Write then read the same address on the next cycle
        step(1'b1, 1'b1, 5'd8, 8'h3C);
        step(1'b1, 1'b0, 5'd8, 8'h00);
        chk("u3.wr_rd", d3, 8'h3C);

        // Counter saturation at CNT_W = 4
        for (int a = 0; a < 20; a++) begin
            step(1'b1, 1'b1, 5'(a), 8'(a));
        end
        chk("u3.wc_sat", wc3, 4'd15);
        chk("u0.wc_nosat", wc0, 16'd21);
        step(1'b0, 1'b0, 5'd0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
